// File: rtl/loader_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART hex loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StHex,
        StAddr,
        StDumpRd,
        StDumpCh,
        StDumpWait
    } state_t;

    typedef enum logic [1:0] {
        CmdNone,
        CmdAddr,
        CmdDump,
        CmdGo
    } cmd_t;

    localparam logic [7:0] CH_AT = 8'h40;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_G  = 8'h47;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Returns {valid, nibble}; accepts both upper and lower case letters.
    function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

    // Uppercase ASCII for one nibble.
    function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'b0, n};
        end
        return 8'h37 + {4'b0, n};
    endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Combinational classifier for one received byte: hex digit, separator or command.
module hex_char_decode
    import loader_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nibble,
    output logic       is_sep,
    output logic [1:0] cmd
);

    logic [4:0] hn;
    assign hn = hex_to_nib(ch);

    // Split the helper result and flag separators and command letters.
    always_comb begin
        is_hex = hn[4];
        nibble = hn[3:0];
        is_sep = (ch == CH_SP) || (ch == CH_CR) || (ch == CH_LF);
        cmd    = CmdNone;
        case (ch)
            CH_AT:   cmd = CmdAddr;
            CH_R:    cmd = CmdDump;
            CH_G:    cmd = CmdGo;
            default: cmd = CmdNone;
        endcase
    end

endmodule

// File: rtl/uart_hex_loader.sv
// Parses an ASCII hex stream from the UART into words, writes them to instruction
// memory, and supports address-set, read-back dump and CPU hold/release commands.
module uart_hex_loader
    import loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned ECHO   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_clr,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   word_cnt,
    output logic              err
);

    localparam int unsigned NIBS  = WORD_W / 4;
    localparam int unsigned NIB_W = $clog2(NIBS + 1);
    localparam logic [NIB_W-1:0]  LAST_NIB = NIB_W'(NIBS - 1);
    localparam logic [NIB_W-1:0]  LF_IDX   = NIB_W'(NIBS);
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX  = '1;

    state_t            state;
    logic [WORD_W-1:0] word;
    logic [NIB_W-1:0]  nib_cnt;
    logic [ADDR_W-1:0] ptr;
    logic              full;
    logic [ADDR_W-1:0] addr_acc;
    logic [ADDR_W-1:0] dump_addr;
    logic [WORD_W-1:0] dump_word;
    logic [NIB_W-1:0]  char_idx;

    logic       dec_hex;
    logic [3:0] dec_nib;
    logic       dec_sep;
    logic [1:0] dec_cmd;

    hex_char_decode u_dec (
        .ch     (rx_data),
        .is_hex (dec_hex),
        .nibble (dec_nib),
        .is_sep (dec_sep),
        .cmd    (dec_cmd)
    );

    logic              consume;
    logic [WORD_W-1:0] next_word;
    logic [ADDR_W+3:0] addr_shift;
    logic [WORD_W-1:0] dump_src;
    logic [7:0]        dump_char;

    // Byte acceptance and datapath helpers. The rx_clr/tx_wr guard blocks the cycle in
    // which the UART has not yet seen our clear or started transmitting the echo.
    always_comb begin
        consume    = rx_valid && !tx_busy && !rx_clr && !tx_wr &&
                     (state == StHex || state == StAddr);
        next_word  = {word[WORD_W-5:0], dec_nib};
        addr_shift = {addr_acc, dec_nib};
        // First character of a dump word comes straight from the memory read port.
        dump_src   = (char_idx == '0) ? mem_rdata : dump_word;
        dump_char  = (char_idx == LF_IDX) ? CH_LF : nib_to_hex(dump_src[WORD_W-1 -: 4]);
    end

    // Main FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StHex;
            word      <= '0;
            nib_cnt   <= '0;
            ptr       <= '0;
            full      <= 1'b0;
            addr_acc  <= '0;
            dump_addr <= '0;
            dump_word <= '0;
            char_idx  <= '0;
            rx_clr    <= 1'b0;
            tx_data   <= '0;
            tx_wr     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            word_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            rx_clr <= 1'b0;
            tx_wr  <= 1'b0;
            mem_we <= 1'b0;
            unique case (state)
                StHex, StAddr: begin
                    if (consume) begin
                        rx_clr <= 1'b1;
                        if (ECHO != 0) begin
                            tx_wr   <= 1'b1;
                            tx_data <= rx_data;
                        end
                        if (state == StHex) begin
                            if (dec_hex) begin
                                cpu_hold <= 1'b1;
                                word     <= next_word;
                                if (nib_cnt == LAST_NIB) begin
                                    nib_cnt <= '0;
                                    if (full) begin
                                        err <= 1'b1;
                                    end else begin
                                        mem_we    <= 1'b1;
                                        mem_addr  <= ptr;
                                        mem_wdata <= next_word;
                                        if (word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
                                        if (ptr == TOP_ADDR) full <= 1'b1;
                                        else ptr <= ptr + 1'b1;
                                    end
                                end else begin
                                    nib_cnt <= nib_cnt + 1'b1;
                                end
                            end else if (dec_sep) begin
                                // Whitespace keeps any partial word.
                            end else if (dec_cmd == CmdAddr) begin
                                nib_cnt  <= '0;
                                addr_acc <= '0;
                                state    <= StAddr;
                            end else if (dec_cmd == CmdGo) begin
                                nib_cnt  <= '0;
                                cpu_hold <= 1'b0;
                            end else if (dec_cmd == CmdDump) begin
                                dump_addr <= '0;
                                char_idx  <= '0;
                                mem_addr  <= '0;
                                state     <= StDumpRd;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            if (dec_hex) begin
                                addr_acc <= addr_shift[ADDR_W-1:0];
                            end else if (dec_sep) begin
                                ptr   <= addr_acc;
                                full  <= 1'b0;
                                state <= StHex;
                            end else begin
                                err   <= 1'b1;
                                state <= StHex;
                            end
                        end
                    end
                end
                StDumpRd: begin
                    state <= StDumpCh;
                end
                StDumpCh: begin
                    if (!tx_busy) begin
                        tx_wr     <= 1'b1;
                        tx_data   <= dump_char;
                        dump_word <= {dump_src[WORD_W-5:0], 4'h0};
                        state     <= StDumpWait;
                    end
                end
                StDumpWait: begin
                    if (!tx_busy) begin
                        if (char_idx == LF_IDX) begin
                            char_idx <= '0;
                            if (dump_addr == TOP_ADDR) begin
                                mem_addr <= ptr;
                                state    <= StHex;
                            end else begin
                                dump_addr <= dump_addr + 1'b1;
                                mem_addr  <= dump_addr + 1'b1;
                                state     <= StDumpRd;
                            end
                        end else begin
                            char_idx <= char_idx + 1'b1;
                            state    <= StDumpCh;
                        end
                    end
                end
                default: state <= StHex;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader: echoes, memory writes and dump text are
// queued as bytes are offered and compared as the DUT emits them.
module tb_uart_hex_loader;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_clr;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic              cpu_hold;
    logic [ADDR_W:0]   word_cnt;
    logic              err;

    always #5 clk = ~clk;

    uart_hex_loader #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ECHO   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_clr    (rx_clr),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_busy   (tx_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold),
        .word_cnt  (word_cnt),
        .err       (err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rx_clr_cnt = 0;
    int bytes_sent = 0;

    logic [7:0]        tx_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [WORD_W-1:0] wd_q[$];
    logic [WORD_W-1:0] ref_mem [DEPTH];

    function automatic logic [WORD_W-1:0] init_val(input int i);
        return 32'hA5000000 | (32'(i) * 32'h00010203);
    endfunction

    // Synchronous-read memory, preloaded on the first clock.
    logic [WORD_W-1:0] mem [DEPTH];
    logic mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Transmitter stays busy for three cycles after each strobe.
    logic [2:0] busy_cnt = 3'd0;
    always @(posedge clk) begin
        if (tx_wr) busy_cnt <= 3'd3;
        else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
    end
    assign tx_busy = (busy_cnt != 3'd0);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_clr) rx_clr_cnt++;
            if (tx_wr) begin
                if (tx_q.size() == 0) begin
                    check_eq("tx_unexpected", 64'(tx_wr), 64'd0);
                end else begin
                    check_eq("tx_data", 64'(tx_data), 64'(tx_q.pop_front()));
                end
            end
            if (mem_we) begin
                if (wa_q.size() == 0) begin
                    check_eq("wr_unexpected", 64'(mem_we), 64'd0);
                end else begin
                    check_eq("wr_addr", 64'(mem_addr), 64'(wa_q.pop_front()));
                    check_eq("wr_data", 64'(mem_wdata), 64'(wd_q.pop_front()));
                end
            end
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
    endfunction

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        wa_q.push_back(a);
        wd_q.push_back(d);
        ref_mem[a] = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        tx_q.push_back(b);
        bytes_sent++;
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(posedge clk); #1;
            if (rx_clr) begin
                @(posedge clk); #1;
                rx_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            check_eq("rx_timeout", 64'(rx_valid), 64'd0);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input bit lower);
        for (int k = 7; k >= 0; k--) send_byte(hexc(w[k*4 +: 4], lower));
        send_byte(8'h20);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 3000 && !idle; n++) begin
            @(posedge clk); #1;
            idle = (tx_q.size() == 0) && (wa_q.size() == 0) && !tx_busy && !tx_wr;
        end
        if (!idle) check_eq("idle_timeout", 64'(tx_q.size() + wa_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_word_cnt", 64'(word_cnt), 64'd0);
        check_eq("rst_strobes", 64'({mem_we, tx_wr, rx_clr}), 64'd0);
        rst = 1'b0;

        // Basic word with an embedded space.
        expect_write(4'd0, 32'h00100093);
        send_str("0010 0093");
        wait_idle();
        check_eq("wc_first", 64'(word_cnt), 64'd1);
        check_eq("err_first", 64'(err), 64'd0);

        // Address set then lowercase word.
        expect_write(4'd3, 32'hDEADBEEF);
        send_str("@3\ndeadbeef");
        wait_idle();
        check_eq("err_addr", 64'(err), 64'd0);
        check_eq("wc_addr", 64'(word_cnt), 64'd2);

        // CPU release / re-hold and a bad character.
        send_byte("G");
        wait_idle();
        check_eq("hold_go", 64'(cpu_hold), 64'd0);
        send_byte("1");
        wait_idle();
        check_eq("hold_digit", 64'(cpu_hold), 64'd1);
        send_byte("Z");
        wait_idle();
        check_eq("err_bad", 64'(err), 64'd1);

        // Reset after five nibbles of a partial word.
        send_str("12345");
        wait_idle();
        do_reset();
        #1;
        check_eq("rst2_wc", 64'(word_cnt), 64'd0);
        check_eq("rst2_err", 64'(err), 64'd0);
        check_eq("rst2_hold", 64'(cpu_hold), 64'd1);
        expect_write(4'd0, 32'h12345678);
        send_str("12345678");
        wait_idle();
        check_eq("wc_after_rst", 64'(word_cnt), 64'd1);

        // Dump: the trailing space must only be consumed once the dump is done.
        send_byte("R");
        for (int a = 0; a < int'(DEPTH); a++) begin
            for (int k = 7; k >= 0; k--) tx_q.push_back(hexc(ref_mem[a][k*4 +: 4], 1'b0));
            tx_q.push_back(8'h0A);
        end
        send_byte(8'h20);
        wait_idle();
        expect_write(4'd1, 32'hCAFEF00D);
        send_str("cafef00d");
        wait_idle();
        check_eq("wc_after_dump", 64'(word_cnt), 64'd2);

        // Fill all of memory then overflow by one word.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            if (k < 16) expect_write(ADDR_W'(k), 32'(k) * 32'h01010101 + 32'h10);
            send_word(32'(k) * 32'h01010101 + 32'h10, k[0]);
            if (k == 15) begin
                wait_idle();
                check_eq("err_at_full", 64'(err), 64'd0);
            end
        end
        wait_idle();
        check_eq("err_overflow", 64'(err), 64'd1);
        check_eq("wc_full", 64'(word_cnt), 64'd16);

        check_eq("rx_clr_count", 64'(rx_clr_cnt), 64'(bytes_sent));
        check_eq("tx_q_left", 64'(tx_q.size()), 64'd0);
        check_eq("wr_q_left", 64'(wa_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_hex_loader.md
# uart_hex_loader

Parametrised successor to the fixed 16×32-bit ASCII-hex instruction loader in the TinyTapeout top. It sits between the UART byte core and the CPU instruction memory. It parses a hex text stream into words of configurable width and writes them to a configurable-depth memory through a write port. Over the previous loader it adds an address-set command, read-back dump, a CPU hold/release handshake, lowercase hex, and error/overflow reporting.

## Interface
Parameters:
- WORD_W, 32, word width in bits; must be a multiple of 4 and 8..64
- DEPTH, 16, number of memory words; power of two, 2..256
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- ECHO, 1, 1 = echo every consumed byte on TX

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART core (dout)
- rx_valid  in  1  byte available (UART rdy)
- rx_clr  out  1  one-cycle pulse: byte consumed (UART rdy_clr)
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit strobe
- tx_busy  in  1  UART transmitter busy
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write/read address
- mem_wdata  out  WORD_W  write data
- mem_rdata  in  WORD_W  read data, valid one cycle after mem_addr
- cpu_hold  out  1  high = CPU must stay in reset/stall
- word_cnt  out  ADDR_W+1  words written since last reset
- err  out  1  sticky: bad character or overflow

## Operation
- All outputs are registered. Reset values are 0, except cpu_hold, which resets to 1.
- A byte is consumed only when rx_valid=1, the FSM is in HEX or ADDR, and tx_busy=0. In that cycle the block pulses rx_clr. If ECHO=1 it also pulses tx_wr with tx_data=rx_data.
- FSM states: HEX, ADDR, DUMP_RD, DUMP_CH, DUMP_WAIT.
- HEX state:
  - Hex digit ('0'-'9', 'A'-'F', 'a'-'f'): shifted into the word register, MSB nibble first. nib_cnt increments.
  - When nib_cnt reaches WORD_W/4: write the word to the current address and clear nib_cnt.
  - After a write, if the pointer < DEPTH-1 it increments. If the pointer is at DEPTH-1, a full flag is set.
  - Any word completed while full is dropped and sets err.
  - Any digit also sets cpu_hold=1.
- '@': discards a partial word, clears addr_acc, and goes to ADDR.
- ADDR state:
  - Hex digits shift into addr_acc; only the low ADDR_W bits are kept.
  - Space, CR or LF loads the pointer from addr_acc, clears full, and returns to HEX.
  - Any other character sets err and returns to HEX with the pointer unchanged.
- Space, CR and LF in HEX: ignored. A partial word is kept across them.
- 'G': discards a partial word and sets cpu_hold=0.
- 'R': enters the dump sequence. The block stops consuming RX bytes until the dump finishes.
  - Memory is read from address 0 to DEPTH-1.
  - Each word is sent as WORD_W/4 uppercase hex characters, MSB first, followed by LF (0x0A).
  - Each character waits for tx_busy=0.
  - The pointer is restored afterwards.
- Any other byte: sets err. The byte is still consumed and echoed.
- err clears only on rst.

## Timing
- Consumption cycle T: rx_clr=1 and tx_wr=1 in T+1.
- Final nibble consumed in T: mem_we=1 with addr/wdata in T+1, and word_cnt updates in T+1.
- cpu_hold changes in T+1.
- Dump per word:
  - DUMP_RD drives mem_addr and captures mem_rdata in the following cycle.
  - Each character then follows the cycle pattern DUMP_CH (tx_wr) → DUMP_WAIT (wait while tx_busy=1, plus one cycle).
  - Minimum cost is 2 cycles per character.
- rst asserted mid-dump or mid-word: the FSM returns to HEX next cycle. The pointer, nib_cnt, word_cnt and err clear, and cpu_hold=1. Memory contents are untouched.
- rx_valid while tx_busy=1: the byte is held and rx_clr stays 0. No byte is ever lost or double-consumed.

## Structure
- A shared package (loader_pkg) holds:
  - the FSM state enum
  - ASCII constants (CH_AT, CH_R, CH_G, CH_SP, CH_CR, CH_LF)
  - the functions hex_to_nib (returns a valid bit) and nib_to_hex
- One natural sub-module, hex_char_decode: combinational byte → {is_hex, nibble, is_sep, cmd}. It is shared by the HEX and ADDR handling.

## Test plan
- Send "0010 0093" with WORD_W=32 → one write at addr 0 of 0x00100093; echo of all 9 bytes; word_cnt=1.
- Send "@3\n" then "deadbeef" → write at addr 3 of 0xDEADBEEF (lowercase accepted); err=0.
- Send 17 words with DEPTH=16 → 16 writes to addrs 0..15; the 17th is dropped; err=1; word_cnt=16.
- Load addr 0 = 0x12345678, then send 'R' → TX stream "12345678\n" followed by DEPTH-1 further lines; no rx_clr during the dump.
- Send 'G' → cpu_hold=0; then send '1' → cpu_hold=1; send 'Z' → err=1 and 'Z' echoed.
- Assert rst after 5 nibbles → next word begins from nibble 0 at addr 0; cpu_hold=1.
